// File: rtl/binary_adder_32_bit_serial.sv
// Bit-serial 32-bit adder: BITS_PER_CYCLE bits per clock through a small ripple of full adders.
// Optional signed-overflow output v is enabled by defining ADDER_OVERFLOW_EN.
module binary_adder_32_bit_serial #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        c0,
    output logic [31:0] s,
    output logic        c32,
`ifdef ADDER_OVERFLOW_EN
    output logic        v,
`endif
    output logic        busy,
    output logic        done
);

    localparam int BPC = BITS_PER_CYCLE;
    localparam int N   = 32 / BPC;
    localparam logic [5:0] LAST_STEP = 6'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    x_q, x_d;
    logic [31:0]    y_q, y_d;
    logic [31:0]    s_q, s_d;
    logic           carry_q, carry_d;
    logic           c32_q, c32_d;
    logic [5:0]     cnt_q, cnt_d;
    logic [BPC+1:0] add_res;
`ifdef ADDER_OVERFLOW_EN
    logic           v_q, v_d;
`endif

    // Returns {carry into the top bit, carry out, sum} of one BPC-bit slice.
    function automatic logic [BPC+1:0] ripple_add(input logic [BPC-1:0] a,
                                                  input logic [BPC-1:0] b,
                                                  input logic           cin);
        logic [BPC-1:0] sum;
        logic           c;
        logic           c_top;
        sum   = '0;
        c     = cin;
        c_top = cin;
        for (int i = 0; i < BPC; i++) begin
            c_top  = c;
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        return {c_top, c, sum};
    endfunction

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        s_d     = s_q;
        carry_d = carry_q;
        c32_d   = c32_q;
        cnt_d   = cnt_q;
`ifdef ADDER_OVERFLOW_EN
        v_d     = v_q;
`endif
        add_res = ripple_add(x_q[BPC-1:0], y_q[BPC-1:0], carry_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = x;
                    y_d     = y;
                    carry_d = c0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Result slices enter from the MSB end so bit 0 settles in s[0] after N steps.
                s_d     = {add_res[BPC-1:0], s_q[31:BPC]};
                x_d     = x_q >> BPC;
                y_d     = y_q >> BPC;
                carry_d = add_res[BPC];
                cnt_d   = cnt_q + 6'd1;
                if (cnt_q == LAST_STEP) begin
                    c32_d   = add_res[BPC];
`ifdef ADDER_OVERFLOW_EN
                    v_d     = add_res[BPC+1] ^ add_res[BPC];
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            carry_q <= 1'b0;
            c32_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef ADDER_OVERFLOW_EN
            v_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            c32_q   <= c32_d;
            cnt_q   <= cnt_d;
`ifdef ADDER_OVERFLOW_EN
            v_q     <= v_d;
`endif
        end
    end

    // Operand shift registers carry no control meaning and need no reset.
    always_ff @(posedge clk) begin
        x_q <= x_d;
        y_q <= y_d;
    end

    assign s    = s_q;
    assign c32  = c32_q;
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
`ifdef ADDER_OVERFLOW_EN
    assign v    = v_q;
`endif

endmodule
